// File: rtl/load_store_unit.sv
// load_store_unit
//   Core-side initiator for the word-wide data memory port. Takes one
//   load/store request from the execute stage, issues word-aligned read/write
//   transactions over a req/ack handshake, performs read-modify-write for
//   sub-word stores, and byte-lane extracts and sign/zero-extends loads.
//   Misaligned accesses, illegal funct3 codes and ack timeouts are reported
//   as faults with no memory request issued for the first two.
//
// Ports
//   i_clk, i_rst        clock (rising edge), synchronous active-high reset
//   i_valid             request strobe, accepted only while o_busy=0
//   i_we                1=store, 0=load
//   i_funct3            RV32I width/sign code
//   i_addr, i_wd        byte address, store data (low bytes for SB/SH)
//   o_rd                extended load result, held until the next accept
//   o_done              one-cycle completion pulse (success or fault)
//   o_busy              high while a request is in flight
//   o_err, o_cause      fault flag and code (01 misaligned, 10 funct3, 11 timeout)
//   o_DM_Addr, o_DM_Wd  word address and write word to memory
//   o_DM_Wen, o_DM_Ren  write/read request, never high together
//   i_DM_Rd, i_DM_ack   read word and memory completion
//
// All outputs are driven straight from registers.

module load_store_unit #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic            i_we,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_addr,
  input  logic [XLEN-1:0] i_wd,
  output logic [XLEN-1:0] o_rd,
  output logic            o_done,
  output logic            o_busy,
  output logic            o_err,
  output logic [1:0]      o_cause,
  output logic [XLEN-1:0] o_DM_Addr,
  output logic [XLEN-1:0] o_DM_Wd,
  output logic            o_DM_Wen,
  output logic            o_DM_Ren,
  input  logic [XLEN-1:0] i_DM_Rd,
  input  logic            i_DM_ack
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD    = 3'd1,
    ST_WR    = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_MISALGN = 2'b01;
  localparam logic [1:0] CAUSE_FUNCT3  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;

  // Counter only needs to reach TIMEOUT-1: the timeout fires on the edge that
  // would have taken it to TIMEOUT.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  // funct3 legality: stores only have the three signed widths.
  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b100, 3'b101:         ok = ~we;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Halfwords need bit 0 clear, words need bits [1:0] clear.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic bad;
    case (f3[1:0])
      2'b01:   bad = lo[0];
      2'b10:   bad = |lo;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Select the addressed lane of a read word and extend it to XLEN.
  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] word,
                                                  input logic [2:0]      f3,
                                                  input logic [1:0]      lo);
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [XLEN-1:0] res;
    case (lo)
      2'b00:   byte_v = word[7:0];
      2'b01:   byte_v = word[15:8];
      2'b10:   byte_v = word[23:16];
      2'b11:   byte_v = word[31:24];
      default: byte_v = word[7:0];
    endcase
    if (lo[1]) begin
      half_v = word[31:16];
    end else begin
      half_v = word[15:0];
    end
    case (f3)
      3'b000:  res = {{24{byte_v[7]}}, byte_v};
      3'b001:  res = {{16{half_v[15]}}, half_v};
      3'b100:  res = {24'h00_0000, byte_v};
      3'b101:  res = {16'h0000, half_v};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace the addressed byte/half of the fetched word with the store data.
  function automatic logic [XLEN-1:0] store_merge(input logic [XLEN-1:0] word,
                                                  input logic [XLEN-1:0] wd,
                                                  input logic [2:0]      f3,
                                                  input logic [1:0]      lo);
    logic [XLEN-1:0] res;
    res = word;
    case (f3[1:0])
      2'b00: begin
        case (lo)
          2'b00:   res[7:0]   = wd[7:0];
          2'b01:   res[15:8]  = wd[7:0];
          2'b10:   res[23:16] = wd[7:0];
          2'b11:   res[31:24] = wd[7:0];
          default: res[7:0]   = wd[7:0];
        endcase
      end
      2'b01: begin
        if (lo[1]) begin
          res[31:16] = wd[15:0];
        end else begin
          res[15:0] = wd[15:0];
        end
      end
      default: res = wd;
    endcase
    return res;
  endfunction

  state_t            state_r, state_s;
  logic              we_r, we_s;
  logic [2:0]        funct3_r, funct3_s;
  logic [1:0]        addr_lo_r, addr_lo_s;
  logic [XLEN-1:0]   wd_r, wd_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [XLEN-1:0]   rd_r, rd_s;
  logic              done_r, done_s;
  logic              busy_r, busy_s;
  logic              err_r, err_s;
  logic [1:0]        cause_r, cause_s;
  logic [XLEN-1:0]   dm_addr_r, dm_addr_s;
  logic [XLEN-1:0]   dm_wd_r, dm_wd_s;
  logic              dm_wen_r, dm_wen_s;
  logic              dm_ren_r, dm_ren_s;
  logic              timeout_hit_s;

  // Timeout fires when the counter sits at its last value and ack is still absent.
  always_comb begin
    timeout_hit_s = 1'b0;
    if (TIMEOUT > 0) begin
      timeout_hit_s = (cnt_r == TO_LAST);
    end else begin
      timeout_hit_s = 1'b0;
    end
  end

  // Next-state and next-output logic; every output register is recomputed here.
  always_comb begin
    state_s   = state_r;
    we_s      = we_r;
    funct3_s  = funct3_r;
    addr_lo_s = addr_lo_r;
    wd_s      = wd_r;
    cnt_s     = cnt_r;
    rd_s      = rd_r;
    done_s    = 1'b0;
    err_s     = 1'b0;
    cause_s   = cause_r;
    dm_addr_s = dm_addr_r;
    dm_wd_s   = dm_wd_r;
    dm_wen_s  = 1'b0;
    dm_ren_s  = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (i_valid) begin
          we_s      = i_we;
          funct3_s  = i_funct3;
          addr_lo_s = i_addr[1:0];
          wd_s      = i_wd;
          dm_addr_s = {i_addr[XLEN-1:2], 2'b00};
          cnt_s     = '0;
          if (!funct3_legal(i_we, i_funct3)) begin
            state_s = ST_FAULT;
            done_s  = 1'b1;
            err_s   = 1'b1;
            cause_s = CAUSE_FUNCT3;
          end else if (misaligned(i_funct3, i_addr[1:0])) begin
            state_s = ST_FAULT;
            done_s  = 1'b1;
            err_s   = 1'b1;
            cause_s = CAUSE_MISALGN;
          end else if (i_we && (i_funct3[1:0] == 2'b10)) begin
            // Full-word store goes straight to the write phase.
            state_s  = ST_WR;
            dm_wen_s = 1'b1;
            dm_wd_s  = i_wd;
          end else begin
            // Loads and sub-word stores both start with a read.
            state_s  = ST_RD;
            dm_ren_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_RD: begin
        if (i_DM_ack) begin
          if (we_r) begin
            state_s  = ST_WR;
            dm_wen_s = 1'b1;
            dm_wd_s  = store_merge(i_DM_Rd, wd_r, funct3_r, addr_lo_r);
            cnt_s    = '0;
          end else begin
            state_s = ST_DONE;
            rd_s    = load_extend(i_DM_Rd, funct3_r, addr_lo_r);
            done_s  = 1'b1;
            cause_s = CAUSE_NONE;
          end
        end else if (timeout_hit_s) begin
          state_s = ST_FAULT;
          done_s  = 1'b1;
          err_s   = 1'b1;
          cause_s = CAUSE_TIMEOUT;
        end else begin
          dm_ren_s = 1'b1;
          cnt_s    = cnt_r + CNT_W'(1);
        end
      end

      ST_WR: begin
        if (i_DM_ack) begin
          state_s = ST_DONE;
          done_s  = 1'b1;
          cause_s = CAUSE_NONE;
        end else if (timeout_hit_s) begin
          state_s = ST_FAULT;
          done_s  = 1'b1;
          err_s   = 1'b1;
          cause_s = CAUSE_TIMEOUT;
        end else begin
          dm_wen_s = 1'b1;
          cnt_s    = cnt_r + CNT_W'(1);
        end
      end

      ST_DONE:  state_s = ST_IDLE;
      ST_FAULT: state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase

    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r   <= ST_IDLE;
      we_r      <= 1'b0;
      funct3_r  <= 3'b000;
      addr_lo_r <= 2'b00;
      wd_r      <= '0;
      cnt_r     <= '0;
      rd_r      <= '0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
      err_r     <= 1'b0;
      cause_r   <= CAUSE_NONE;
      dm_addr_r <= '0;
      dm_wd_r   <= '0;
      dm_wen_r  <= 1'b0;
      dm_ren_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      we_r      <= we_s;
      funct3_r  <= funct3_s;
      addr_lo_r <= addr_lo_s;
      wd_r      <= wd_s;
      cnt_r     <= cnt_s;
      rd_r      <= rd_s;
      done_r    <= done_s;
      busy_r    <= busy_s;
      err_r     <= err_s;
      cause_r   <= cause_s;
      dm_addr_r <= dm_addr_s;
      dm_wd_r   <= dm_wd_s;
      dm_wen_r  <= dm_wen_s;
      dm_ren_r  <= dm_ren_s;
    end
  end

  assign o_rd      = rd_r;
  assign o_done    = done_r;
  assign o_busy    = busy_r;
  assign o_err     = err_r;
  assign o_cause   = cause_r;
  assign o_DM_Addr = dm_addr_r;
  assign o_DM_Wd   = dm_wd_r;
  assign o_DM_Wen  = dm_wen_r;
  assign o_DM_Ren  = dm_ren_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit. Inputs are driven 1 ns after each
// rising edge and outputs are observed at the same point. The cycle in which
// i_valid is presented is cycle 0.

module tb_load_store_unit;

  logic        i_clk;
  logic        i_rst;
  logic        i_valid;
  logic        i_we;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wd;
  logic [31:0] o_rd;
  logic        o_done;
  logic        o_busy;
  logic        o_err;
  logic [1:0]  o_cause;
  logic [31:0] o_DM_Addr;
  logic [31:0] o_DM_Wd;
  logic        o_DM_Wen;
  logic        o_DM_Ren;
  logic [31:0] i_DM_Rd;
  logic        i_DM_ack;

  int pass_cnt;
  int total_cnt;

  // Results recorded by run_txn
  int          r_ren_cyc, r_wen_cyc, r_reads, r_writes, r_done_cyc, r_done_cnt;
  logic        r_both, r_err, r_busy1;
  logic [1:0]  r_cause;
  logic [31:0] r_rd, r_rd_addr, r_wr_addr, r_wd;

  load_store_unit #(.XLEN(32), .TIMEOUT(16)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_valid   (i_valid),
    .i_we      (i_we),
    .i_funct3  (i_funct3),
    .i_addr    (i_addr),
    .i_wd      (i_wd),
    .o_rd      (o_rd),
    .o_done    (o_done),
    .o_busy    (o_busy),
    .o_err     (o_err),
    .o_cause   (o_cause),
    .o_DM_Addr (o_DM_Addr),
    .o_DM_Wd   (o_DM_Wd),
    .o_DM_Wen  (o_DM_Wen),
    .o_DM_Ren  (o_DM_Ren),
    .i_DM_Rd   (i_DM_Rd),
    .i_DM_ack  (i_DM_ack)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Present one request in cycle 0, then act as memory for max_cyc cycles.
  // ack_wait = number of wait cycles before ack for each request; -1 = never.
  task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] rdata,
                         input int ack_wait, input int max_cyc);
    int   age;
    logic prev_ren, prev_wen;
    r_ren_cyc = 0; r_wen_cyc = 0; r_reads = 0; r_writes = 0;
    r_done_cyc = -1; r_done_cnt = 0; r_both = 1'b0; r_err = 1'b0; r_busy1 = 1'b0;
    r_cause = 2'b00; r_rd = 32'h0; r_rd_addr = 32'hFFFF_FFFF; r_wr_addr = 32'hFFFF_FFFF;
    r_wd = 32'h0;
    i_valid = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wd = wd;
    i_DM_ack = 1'b0; i_DM_Rd = rdata;
    tick();
    i_valid = 1'b0;
    prev_ren = 1'b0; prev_wen = 1'b0; age = 0;
    for (int c = 1; c <= max_cyc; c++) begin
      if (c == 1) r_busy1 = o_busy;
      if (o_DM_Ren && o_DM_Wen) r_both = 1'b1;
      if ((o_DM_Ren != prev_ren) || (o_DM_Wen != prev_wen)) age = 0;
      if (o_DM_Ren) begin
        r_ren_cyc++;
        if (!prev_ren) begin r_reads++; r_rd_addr = o_DM_Addr; end
      end
      if (o_DM_Wen) begin
        r_wen_cyc++;
        r_wd = o_DM_Wd;
        if (!prev_wen) begin r_writes++; r_wr_addr = o_DM_Addr; end
      end
      if (o_done) begin
        r_done_cnt++;
        if (r_done_cyc < 0) begin
          r_done_cyc = c; r_err = o_err; r_cause = o_cause; r_rd = o_rd;
        end
      end
      i_DM_ack = (o_DM_Ren || o_DM_Wen) && (ack_wait >= 0) && (age == ack_wait);
      age++;
      prev_ren = o_DM_Ren; prev_wen = o_DM_Wen;
      tick();
    end
    i_DM_ack = 1'b0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    tick(); tick();
    total_cnt++;
    if ({o_done, o_busy, o_err, o_cause, o_DM_Wen, o_DM_Ren} !== 7'b0)
      $display("FAIL reset_flags: got %b expected 0000000", {o_done, o_busy, o_err, o_cause, o_DM_Wen, o_DM_Ren});
    else pass_cnt++;
    total_cnt++;
    if ({o_rd, o_DM_Addr, o_DM_Wd} !== 96'h0)
      $display("FAIL reset_data: got %h expected 0", {o_rd, o_DM_Addr, o_DM_Wd});
    else pass_cnt++;
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_lw();
    run_txn(1'b0, 3'b010, 32'h0000_0104, 32'h0, 32'h8899_AABB, 3, 8);
    total_cnt++;
    if (r_ren_cyc !== 4) $display("FAIL lw_ren_cycles: got %0d expected 4", r_ren_cyc);
    else pass_cnt++;
    total_cnt++;
    if (r_rd_addr !== 32'h0000_0104) $display("FAIL lw_addr: got %h expected 00000104", r_rd_addr);
    else pass_cnt++;
    total_cnt++;
    if (r_rd !== 32'h8899_AABB) $display("FAIL lw_rd: got %h expected 8899aabb", r_rd);
    else pass_cnt++;
    total_cnt++;
    if ({r_done_cyc, r_done_cnt} !== {32'd5, 32'd1})
      $display("FAIL lw_done: got cycle %0d count %0d expected cycle 5 count 1", r_done_cyc, r_done_cnt);
    else pass_cnt++;
    total_cnt++;
    if ({r_err, r_wen_cyc, r_busy1} !== {1'b0, 32'd0, 1'b1})
      $display("FAIL lw_err_wen_busy: got err %b wen %0d busy %b expected 0 0 1", r_err, r_wen_cyc, r_busy1);
    else pass_cnt++;
  endtask

  task automatic test_load_ext();
    run_txn(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h8011_2233, 0, 4);
    total_cnt++;
    if ({r_rd, r_done_cyc} !== {32'hFFFF_FF80, 32'd2})
      $display("FAIL lb_sign: got %h at cycle %0d expected ffffff80 at 2", r_rd, r_done_cyc);
    else pass_cnt++;
    run_txn(1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h8011_2233, 0, 4);
    total_cnt++;
    if (r_rd !== 32'h0000_0080) $display("FAIL lbu_zero: got %h expected 00000080", r_rd);
    else pass_cnt++;
    run_txn(1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h8011_2233, 0, 4);
    total_cnt++;
    if (r_rd !== 32'hFFFF_8011) $display("FAIL lh_sign: got %h expected ffff8011", r_rd);
    else pass_cnt++;
    run_txn(1'b0, 3'b101, 32'h0000_0100, 32'h0, 32'h8011_A233, 0, 4);
    total_cnt++;
    if (r_rd !== 32'h0000_A233) $display("FAIL lhu_zero: got %h expected 0000a233", r_rd);
    else pass_cnt++;
    run_txn(1'b0, 3'b000, 32'h0000_0101, 32'h0, 32'h8011_2233, 0, 4);
    total_cnt++;
    if (r_rd !== 32'h0000_0022) $display("FAIL lb_pos: got %h expected 00000022", r_rd);
    else pass_cnt++;
  endtask

  task automatic test_store();
    run_txn(1'b1, 3'b000, 32'h0000_0101, 32'h0000_00EE, 32'h1122_3344, 0, 5);
    total_cnt++;
    if ({r_reads, r_writes} !== {32'd1, 32'd1})
      $display("FAIL sb_rmw_count: got reads %0d writes %0d expected 1 1", r_reads, r_writes);
    else pass_cnt++;
    total_cnt++;
    if ({r_rd_addr, r_wr_addr} !== {32'h0000_0100, 32'h0000_0100})
      $display("FAIL sb_addr: got rd %h wr %h expected 00000100 00000100", r_rd_addr, r_wr_addr);
    else pass_cnt++;
    total_cnt++;
    if (r_wd !== 32'h1122_EE44) $display("FAIL sb_wd: got %h expected 1122ee44", r_wd);
    else pass_cnt++;
    total_cnt++;
    if ({r_done_cyc, r_err, r_both} !== {32'd3, 1'b0, 1'b0})
      $display("FAIL sb_done: got cycle %0d err %b both %b expected 3 0 0", r_done_cyc, r_err, r_both);
    else pass_cnt++;
    run_txn(1'b1, 3'b001, 32'h0000_0102, 32'h0000_BEEF, 32'h1122_3344, 0, 5);
    total_cnt++;
    if ({r_wd, r_done_cyc} !== {32'hBEEF_3344, 32'd3})
      $display("FAIL sh_wd: got %h at cycle %0d expected beef3344 at 3", r_wd, r_done_cyc);
    else pass_cnt++;
    run_txn(1'b1, 3'b010, 32'h0000_0108, 32'hCAFE_F00D, 32'h1122_3344, 0, 4);
    total_cnt++;
    if ({r_wd, r_wr_addr, r_reads, r_done_cyc} !== {32'hCAFE_F00D, 32'h0000_0108, 32'd0, 32'd2})
      $display("FAIL sw: got wd %h addr %h reads %0d cycle %0d expected cafef00d 00000108 0 2",
               r_wd, r_wr_addr, r_reads, r_done_cyc);
    else pass_cnt++;
  endtask

  task automatic test_faults();
    run_txn(1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'h0, 0, 3);
    total_cnt++;
    if ({r_done_cyc, r_err, r_cause, r_reads, r_writes} !== {32'd1, 1'b1, 2'b01, 32'd0, 32'd0})
      $display("FAIL lw_misalign: got cycle %0d err %b cause %b reads %0d writes %0d expected 1 1 01 0 0",
               r_done_cyc, r_err, r_cause, r_reads, r_writes);
    else pass_cnt++;
    run_txn(1'b0, 3'b011, 32'h0000_0101, 32'h0, 32'h0, 0, 3);
    total_cnt++;
    if ({r_done_cyc, r_err, r_cause, r_reads, r_writes} !== {32'd1, 1'b1, 2'b10, 32'd0, 32'd0})
      $display("FAIL funct3_priority: got cycle %0d err %b cause %b reads %0d writes %0d expected 1 1 10 0 0",
               r_done_cyc, r_err, r_cause, r_reads, r_writes);
    else pass_cnt++;
    run_txn(1'b1, 3'b100, 32'h0000_0100, 32'h0, 32'h0, 0, 3);
    total_cnt++;
    if ({r_cause, r_writes, r_reads} !== {2'b10, 32'd0, 32'd0})
      $display("FAIL store_f3_100: got cause %b writes %0d reads %0d expected 10 0 0", r_cause, r_writes, r_reads);
    else pass_cnt++;
    run_txn(1'b1, 3'b001, 32'h0000_0101, 32'h0, 32'h0, 0, 3);
    total_cnt++;
    if ({r_cause, r_reads, r_done_cnt} !== {2'b01, 32'd0, 32'd1})
      $display("FAIL sh_misalign: got cause %b reads %0d dones %0d expected 01 0 1", r_cause, r_reads, r_done_cnt);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    run_txn(1'b1, 3'b001, 32'h0000_0200, 32'h0000_1234, 32'h0, -1, 20);
    total_cnt++;
    if (r_ren_cyc !== 16) $display("FAIL to_ren_cycles: got %0d expected 16", r_ren_cyc);
    else pass_cnt++;
    total_cnt++;
    if ({r_done_cyc, r_err, r_cause} !== {32'd17, 1'b1, 2'b11})
      $display("FAIL to_fault: got cycle %0d err %b cause %b expected 17 1 11", r_done_cyc, r_err, r_cause);
    else pass_cnt++;
    total_cnt++;
    if (r_wen_cyc !== 0) $display("FAIL to_no_write: got %0d wen cycles expected 0", r_wen_cyc);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int req_seen;
    // i_valid held high while busy must not be queued
    i_valid = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h0000_0010;
    i_wd = 32'h0; i_DM_Rd = 32'h0000_0077; i_DM_ack = 1'b0;
    tick();
    i_we = 1'b1; i_addr = 32'h0000_0020; i_DM_ack = 1'b1;
    total_cnt++;
    if ({o_busy, o_DM_Ren} !== 2'b11) $display("FAIL b2b_busy_c1: got %b expected 11", {o_busy, o_DM_Ren});
    else pass_cnt++;
    tick();
    i_valid = 1'b0; i_DM_ack = 1'b0;
    total_cnt++;
    if ({o_done, o_busy, o_rd} !== {1'b1, 1'b1, 32'h0000_0077})
      $display("FAIL b2b_done_c2: got done %b busy %b rd %h expected 1 1 00000077", o_done, o_busy, o_rd);
    else pass_cnt++;
    req_seen = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (o_DM_Ren || o_DM_Wen || o_busy) req_seen++;
    end
    total_cnt++;
    if (req_seen !== 0) $display("FAIL b2b_not_queued: got %0d busy cycles expected 0", req_seen);
    else pass_cnt++;
    // New request presented in the IDLE cycle right after DONE
    run_txn(1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'h1111_2222, 0, 2);
    total_cnt++;
    if (o_busy !== 1'b0) $display("FAIL b2b_idle_after_done: got busy %b expected 0", o_busy);
    else pass_cnt++;
    run_txn(1'b0, 3'b010, 32'h0000_0044, 32'h0, 32'h3333_4444, 0, 3);
    total_cnt++;
    if ({r_rd, r_done_cyc} !== {32'h3333_4444, 32'd2})
      $display("FAIL b2b_second: got %h at cycle %0d expected 33334444 at 2", r_rd, r_done_cyc);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_wr();
    int bad;
    i_valid = 1'b1; i_we = 1'b1; i_funct3 = 3'b010; i_addr = 32'h0000_0300;
    i_wd = 32'h1234_5678; i_DM_ack = 1'b0;
    tick();
    i_valid = 1'b0;
    total_cnt++;
    if ({o_DM_Wen, o_DM_Wd} !== {1'b1, 32'h1234_5678})
      $display("FAIL rst_wr_started: got wen %b wd %h expected 1 12345678", o_DM_Wen, o_DM_Wd);
    else pass_cnt++;
    tick();
    i_rst = 1'b1;
    tick();
    total_cnt++;
    if ({o_rd, o_done, o_busy, o_err, o_cause, o_DM_Addr, o_DM_Wd, o_DM_Wen, o_DM_Ren} !== 103'h0)
      $display("FAIL rst_mid_wr: got %h expected 0",
               {o_rd, o_done, o_busy, o_err, o_cause, o_DM_Addr, o_DM_Wd, o_DM_Wen, o_DM_Ren});
    else pass_cnt++;
    i_rst = 1'b0;
    // Stray ack while idle must be ignored
    i_DM_ack = 1'b1;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (o_DM_Wen || o_DM_Ren || o_done) bad++;
    end
    i_DM_ack = 1'b0;
    total_cnt++;
    if (bad !== 0) $display("FAIL rst_no_write_after: got %0d active cycles expected 0", bad);
    else pass_cnt++;
    run_txn(1'b0, 3'b010, 32'h0000_0000, 32'h0, 32'hA5A5_5A5A, 0, 4);
    total_cnt++;
    if ({r_rd, r_done_cyc, r_err, r_rd_addr} !== {32'hA5A5_5A5A, 32'd2, 1'b0, 32'h0})
      $display("FAIL rst_then_lw: got rd %h cycle %0d err %b addr %h expected a5a55a5a 2 0 00000000",
               r_rd, r_done_cyc, r_err, r_rd_addr);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    i_rst = 1'b1; i_valid = 1'b0; i_we = 1'b0; i_funct3 = 3'b000;
    i_addr = 32'h0; i_wd = 32'h0; i_DM_Rd = 32'h0; i_DM_ack = 1'b0;
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_faults();
    test_timeout();
    test_back_to_back();
    test_reset_mid_wr();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
